// File: rtl/rv32i_sc_core.sv
// Single-cycle RV32I core: fetch, decode, execute, data access and writeback
// all complete within one CLK period.
module rv32i_sc_core #(
    parameter int unsigned IMEM_WORDS = 1024,
    parameter int unsigned DMEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC   = 32'd4
) (
    input  logic        CLK,
    input  logic        RST_X,
    output logic [31:0] pc,
    output logic [31:0] instr,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned IAW  = $clog2(IMEM_WORDS);
    localparam int unsigned DAW  = $clog2(DMEM_WORDS);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [XLEN-1:0] mem  [IMEM_WORDS];
    logic [XLEN-1:0] dmem [DMEM_WORDS];
    logic [XLEN-1:0] x    [NREG];

    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2, shamt;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] rs1v, rs2v, op_b, alu_res, ld_data, next_pc, wb_data;
    logic            br_taken, wb_en, st_en;
    logic [DAW-1:0]  daddr;

    assign instr = mem[IAW'(pc >> 2)];

    // Field extraction and immediate formats
    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign funct7b5 = instr[30];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u    = {instr[31:12], 12'b0};
    assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign rs1v      = (rs1 == 5'd0) ? '0 : x[rs1];
    assign rs2v      = (rs2 == 5'd0) ? '0 : x[rs2];
    assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : x[dbg_raddr];

    // Word address wraps naturally by keeping only the index bits
    assign daddr   = DAW'((rs1v + ((opcode == OP_STORE) ? imm_s : imm_i)) >> 2);
    assign ld_data = dmem[daddr];

    always_comb begin
        op_b    = (opcode == OP_REG) ? rs2v : imm_i;
        shamt   = op_b[4:0];
        alu_res = '0;
        case (funct3)
            3'b000:  alu_res = (opcode == OP_REG && funct7b5) ? rs1v - op_b : rs1v + op_b;
            3'b001:  alu_res = rs1v << shamt;
            3'b010:  alu_res = {31'b0, $signed(rs1v) < $signed(op_b)};
            3'b011:  alu_res = {31'b0, rs1v < op_b};
            3'b100:  alu_res = rs1v ^ op_b;
            3'b101:  alu_res = funct7b5 ? XLEN'($signed(rs1v) >>> shamt) : rs1v >> shamt;
            3'b110:  alu_res = rs1v | op_b;
            default: alu_res = rs1v & op_b;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1v == rs2v);
            3'b001:  br_taken = (rs1v != rs2v);
            3'b100:  br_taken = ($signed(rs1v) <  $signed(rs2v));
            3'b101:  br_taken = ($signed(rs1v) >= $signed(rs2v));
            3'b110:  br_taken = (rs1v <  rs2v);
            3'b111:  br_taken = (rs1v >= rs2v);
            default: br_taken = 1'b0;
        endcase
    end

    // Next-PC, writeback and store control; unknown opcodes fall through as no-ops
    always_comb begin
        next_pc = pc + 32'd4;
        wb_en   = 1'b0;
        wb_data = '0;
        st_en   = 1'b0;
        case (opcode)
            OP_LUI:   begin wb_en = 1'b1; wb_data = imm_u; end
            OP_AUIPC: begin wb_en = 1'b1; wb_data = pc + imm_u; end
            OP_JAL: begin
                wb_en   = 1'b1;
                wb_data = pc + 32'd4;
                next_pc = pc + imm_j;
            end
            OP_JALR: begin
                wb_en   = 1'b1;
                wb_data = pc + 32'd4;
                next_pc = (rs1v + imm_i) & ~32'd1;
            end
            OP_BRANCH: if (br_taken) next_pc = pc + imm_b;
            OP_LOAD:   begin wb_en = 1'b1; wb_data = ld_data; end
            OP_STORE:  st_en = 1'b1;
            OP_IMM,
            OP_REG:    begin wb_en = 1'b1; wb_data = alu_res; end
            default:   ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            pc <= RESET_PC;
            for (int i = 0; i < int'(NREG); i++) x[i] <= '0;
        end else begin
            pc <= next_pc;
            if (wb_en && rd != 5'd0) x[rd] <= wb_data;
        end
    end

    // Data memory has no reset; reset only suppresses the write
    always_ff @(posedge CLK) begin
        if (RST_X && st_en) dmem[daddr] <= rs2v;
    end

endmodule

// File: tb/tb_rv32i_sc_core.sv
// Bench for rv32i_sc_core: directed programs plus random programs, each step
// compared against an instruction-level reference model.
module tb_rv32i_sc_core;

    localparam logic [31:0] RESET_PC = 32'd4;

    logic        CLK;
    logic        RST_X;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rim [1024];
    logic [31:0] rdm [1024];
    logic [31:0] rx  [32];
    logic [31:0] rpc;

    rv32i_sc_core dut (
        .CLK(CLK), .RST_X(RST_X), .pc(pc), .instr(instr),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    initial CLK = 1'b0;
    always #50 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Instruction encoders
    function automatic logic [31:0] i_type(int op, int f3, int rd, int rs1, int imm);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] r_type(int f7, int f3, int rd, int rs1, int rs2);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] s_type(int rs2, int rs1, int imm);
        logic [11:0] m;
        m = 12'(imm);
        return {m[11:5], 5'(rs2), 5'(rs1), 3'd2, m[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] b_type(int f3, int rs1, int rs2, int imm);
        logic [12:0] m;
        m = 13'(imm);
        return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:1], m[11], 7'h63};
    endfunction
    function automatic logic [31:0] u_type(int op, int rd, int imm20);
        return {20'(imm20), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] j_type(int rd, int imm);
        logic [20:0] m;
        m = 21'(imm);
        return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6F};
    endfunction

    function automatic logic [31:0] alu_ref(logic [2:0] f3, logic alt, logic [31:0] a, logic [31:0] b);
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic bit br_ref(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Reference model: one architectural instruction (or reset) per call
    task automatic model_step(input bit rst_n);
        logic [31:0] iw, a, b, ii, is_, ib, ij, iu, res, npc, ea;
        bit wr;
        if (!rst_n) begin
            rpc = RESET_PC;
            for (int i = 0; i < 32; i++) rx[i] = '0;
            return;
        end
        iw  = rim[rpc[11:2]];
        a   = rx[iw[19:15]];
        b   = rx[iw[24:20]];
        ii  = 32'($signed(iw) >>> 20);
        is_ = 32'($signed({iw[31:25], iw[11:7], 20'b0}) >>> 20);
        ib  = 32'($signed({iw[31], iw[7], iw[30:25], iw[11:8], 20'b0}) >>> 19);
        ij  = 32'($signed({iw[31], iw[19:12], iw[20], iw[30:21], 12'b0}) >>> 11);
        iu  = {iw[31:12], 12'b0};
        npc = rpc + 32'd4;
        wr  = 1'b0;
        res = '0;
        case (iw[6:0])
            7'h37: begin wr = 1'b1; res = iu; end
            7'h17: begin wr = 1'b1; res = rpc + iu; end
            7'h6F: begin wr = 1'b1; res = rpc + 32'd4; npc = rpc + ij; end
            7'h67: begin wr = 1'b1; res = rpc + 32'd4; npc = (a + ii) & ~32'd1; end
            7'h63: if (br_ref(iw[14:12], a, b)) npc = rpc + ib;
            7'h03: begin ea = a + ii; wr = 1'b1; res = rdm[ea[11:2]]; end
            7'h23: begin ea = a + is_; rdm[ea[11:2]] = b; end
            7'h13: begin wr = 1'b1; res = alu_ref(iw[14:12], iw[14:12] == 3'd5 && iw[30], a, ii); end
            7'h33: begin wr = 1'b1; res = alu_ref(iw[14:12], iw[30], a, b); end
            default: ;
        endcase
        if (wr && iw[11:7] != 5'd0) rx[iw[11:7]] = res;
        rpc = npc;
    endtask

    task automatic put(input int idx, input logic [31:0] w);
        dut.mem[idx] = w;
        rim[idx] = w;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) put(i, 32'h0);
    endtask

    task automatic chk_reg(input string tag, input int r, input logic [31:0] exp);
        dbg_raddr = 5'(r);
        #1;
        check(tag, dbg_rdata, exp);
    endtask

    // One clock: drive reset, advance model, compare pc/instr and a random register
    task automatic step(input bit rst_n);
        int r;
        RST_X = rst_n;
        model_step(rst_n);
        @(posedge CLK);
        #1;
        check("pc", pc, rpc);
        check("instr", instr, rim[rpc[11:2]]);
        r = $urandom_range(0, 31);
        chk_reg($sformatf("x%0d_step", r), r, rx[r]);
    endtask

    function automatic logic [31:0] gen_rand();
        logic [31:0] w;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [2:0]  bf [6];
        int rd, rs1, rs2;
        bf  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        rd  = $urandom_range(0, 15);
        rs1 = $urandom_range(0, 15);
        rs2 = $urandom_range(0, 15);
        f3  = 3'($urandom_range(0, 7));
        imm = 12'($urandom);
        case ($urandom_range(0, 10))
            0, 1: begin
                if (f3 == 3'd1) imm = {7'd0, imm[4:0]};
                else if (f3 == 3'd5) imm = {1'b0, imm[10], 5'd0, imm[4:0]};
                w = i_type('h13, int'(f3), rd, rs1, int'(imm));
            end
            2, 3:    w = r_type(((f3 == 3'd0 || f3 == 3'd5) && imm[0]) ? 'h20 : 0, int'(f3), rd, rs1, rs2);
            4:       w = u_type('h37, rd, int'($urandom));
            5:       w = u_type('h17, rd, int'($urandom));
            6:       w = s_type(rs2, 0, $urandom_range(0, 63));
            7:       w = i_type('h03, 2, rd, 0, $urandom_range(0, 63));
            8:       w = b_type(int'(bf[$urandom_range(0, 5)]), rs1, rs2, 4 * $urandom_range(1, 4));
            9:       w = j_type(rd, 4 * $urandom_range(1, 4));
            default: w = imm[0] ? 32'h0000000F : 32'h00000073;
        endcase
        return w;
    endfunction

    initial begin
        RST_X     = 1'b0;
        dbg_raddr = 5'd0;

        // Straight-line ALU sequence
        clear_prog();
        put(1, i_type('h13, 0, 5, 0, -42));
        put(2, i_type('h13, 0, 6, 0, 42));
        put(3, r_type(0, 0, 7, 5, 6));
        step(0);
        check("rst_pc", pc, 32'd4);
        chk_reg("rst_x5", 5, 32'd0);
        step(1); check("t1_pc8", pc, 32'd8);
        step(1); check("t1_pc12", pc, 32'd12);
        step(1); check("t1_pc16", pc, 32'd16);
        chk_reg("t1_x5", 5, 32'hFFFFFFD6);
        chk_reg("t1_x6", 6, 32'd42);
        chk_reg("t1_x7", 7, 32'd0);

        // JAL, stack-style wrap addressing, JALR to pc 0
        clear_prog();
        put(1, i_type('h13, 0, 10, 0, 5));
        put(2, i_type('h13, 0, 2, 0, 0));
        put(3, 32'h0E8000EF);
        put(61, s_type(10, 2, 0));
        put(62, i_type('h13, 0, 2, 2, -4));
        put(63, i_type('h03, 2, 7, 2, 4));
        put(64, s_type(10, 2, 0));
        put(65, r_type(0, 6, 1, 0, 0));
        put(66, i_type('h67, 0, 0, 1, 0));
        step(0); step(1); step(1); step(1);
        check("t2_pc244", pc, 32'd244);
        chk_reg("t2_x1", 1, 32'd16);
        step(1); check("t2_dmem0", dut.dmem[0], 32'd5);
        step(1); chk_reg("t2_x2", 2, 32'hFFFFFFFC);
        step(1); chk_reg("t2_x7", 7, 32'd5);
        step(1); check("t2_dmem1023", dut.dmem[1023], 32'd5);
        for (int k = 0; k < 20 && pc[11:2] != 10'd0; k++) step(1);
        check("t3_halt_pc", pc, 32'd0);
        chk_reg("t3_x1", 1, 32'd0);
        chk_reg("t3_x0", 0, 32'd0);

        // Branches, shifts, x0 writes, LUI/AUIPC, JALR rd==rs1, reset during a store
        clear_prog();
        put(1, i_type('h13, 0, 5, 0, -1));
        put(2, i_type('h13, 0, 6, 0, 1));
        put(3, b_type(4, 5, 6, 8));
        put(4, i_type('h13, 0, 20, 0, 99));
        put(5, b_type(6, 5, 6, 8));
        put(6, r_type('h20, 0, 7, 6, 5));
        put(7, i_type('h13, 5, 8, 5, 'h404));
        put(8, i_type('h13, 5, 9, 5, 28));
        put(9, i_type('h13, 0, 0, 0, 5));
        put(10, u_type('h37, 3, 'h12345));
        put(11, u_type('h17, 4, 1));
        put(12, i_type('h13, 0, 11, 0, 52));
        put(13, i_type('h67, 0, 11, 11, 5));
        put(14, s_type(0, 0, 8));
        put(15, s_type(3, 0, 8));
        step(0); step(1); step(1); step(1);
        check("t4_blt_taken", pc, 32'd20);
        step(1); check("t4_bltu_not", pc, 32'd24);
        for (int k = 0; k < 6; k++) step(1);
        chk_reg("t4_x20", 20, 32'd0);
        chk_reg("t4_sub", 7, 32'd2);
        chk_reg("t4_srai", 8, 32'hFFFFFFFF);
        chk_reg("t4_srli", 9, 32'd15);
        chk_reg("t5_dbg0", 0, 32'd0);
        chk_reg("t5_lui", 3, 32'h12345000);
        chk_reg("t5_auipc", 4, 32'd4140);
        step(1); step(1);
        check("jalr_pc", pc, 32'd56);
        chk_reg("jalr_x11", 11, 32'd56);
        step(1);
        step(0);
        check("t6_rst_pc", pc, 32'd4);
        check("t6_no_store", dut.dmem[2], 32'd0);
        chk_reg("t6_x3", 3, 32'd0);
        chk_reg("t6_x11", 11, 32'd0);
        step(1);
        check("t6_restart_pc", pc, 32'd8);
        chk_reg("t6_x5", 5, 32'hFFFFFFFF);

        // Random forward-only programs with occasional mid-run reset
        for (int p = 0; p < 6; p++) begin
            clear_prog();
            for (int i = 0; i < 16; i++) put(1 + i, s_type(0, 0, 4 * i));
            for (int i = 17; i < 520; i++) put(i, gen_rand());
            step(0);
            for (int c = 0; c < 120; c++) step(($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1);
            for (int i = 1; i < 32; i++) chk_reg($sformatf("p%0d_x%0d", p, i), i, rx[i]);
            for (int i = 0; i < 16; i++) check($sformatf("p%0d_dmem%0d", p, i), dut.dmem[i], rdm[i]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
